// File: rtl/dual_issue_fetch_buffer.sv
// Program-ordered instruction queue feeding the dual-issue decoder; presents the two oldest entries.
// Optional same-cycle empty-buffer bypass under `define DUAL_ISSUE_FETCH_BUF_BYPASS_EN.
module dual_issue_fetch_buffer #(
    parameter int els_p         = 8,
    parameter int instr_width_p = 32,
    parameter int pc_width_p    = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               flush_i,
    input  logic                               enq_v_i,
    input  logic [instr_width_p-1:0]           enq_instr_i,
    input  logic [pc_width_p-1:0]              enq_pc_i,
    output logic                               enq_ready_o,
    output logic [1:0]                         deq_v_o,
    output logic [1:0][instr_width_p-1:0]      deq_instr_o,
    output logic [1:0][pc_width_p-1:0]         deq_pc_o,
    input  logic [1:0]                         deq_count_i,
    output logic [$clog2(els_p):0]             count_o
);
    localparam int AW = $clog2(els_p);
    localparam int PW = AW + 1;
    localparam logic [AW:0] CNT_ONE  = PW'(1);
    localparam logic [AW:0] CNT_TWO  = PW'(2);
    localparam logic [AW:0] CNT_FULL = PW'(els_p);

    typedef struct packed {
        logic [instr_width_p-1:0] instr;
        logic [pc_width_p-1:0]    pc;
    } entry_t;

    typedef enum logic {RUN, FLUSH} state_e;

    entry_t      mem_q [els_p];
    logic [AW:0] rptr_q, rptr_d, wptr_q, wptr_d;
    state_e      state_q, state_d;

    logic [AW-1:0] rd0_idx, rd1_idx;
    logic          full, empty, enq_fire, wr_en, bypass, clamp;
    logic [1:0]    stored_v, avail, deq_eff;

    assign count_o  = wptr_q - rptr_q;
    assign full     = (count_o == CNT_FULL);
    assign empty    = (count_o == '0);
    assign rd0_idx  = rptr_q[AW-1:0];
    assign rd1_idx  = rd0_idx + 1'b1;
    assign enq_fire = enq_v_i & enq_ready_o & ~flush_i;

`ifdef DUAL_ISSUE_FETCH_BUF_BYPASS_EN
    // enq_ready_o already implies RUN, so this is "empty in RUN with an enqueue"
    assign bypass = enq_fire & empty;
`else
    assign bypass = 1'b0;
`endif

    assign stored_v = (count_o >= CNT_TWO) ? 2'd2 : ((count_o >= CNT_ONE) ? 2'd1 : 2'd0);
    assign avail    = bypass ? 2'd1 : stored_v;
    assign clamp    = ~flush_i & (deq_count_i > avail);
    assign deq_eff  = (deq_count_i > avail) ? avail : deq_count_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= RUN;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i) state_d = FLUSH;
            FLUSH:   state_d = flush_i ? FLUSH : RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        enq_ready_o = (state_q == RUN) && !full;
    end

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        wr_en  = 1'b0;
        if (flush_i) begin
            rptr_d = wptr_q;
        end else if (bypass && deq_eff != 2'd0) begin
            // bypassed entry retired straight from the input; nothing stored
            rptr_d = rptr_q;
        end else begin
            rptr_d = rptr_q + PW'(deq_eff);
            if (enq_fire) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= '{instr: enq_instr_i, pc: enq_pc_i};
    end

    always_comb begin
        deq_v_o        = {(count_o >= CNT_TWO), (count_o >= CNT_ONE)};
        deq_instr_o[0] = mem_q[rd0_idx].instr;
        deq_pc_o[0]    = mem_q[rd0_idx].pc;
        deq_instr_o[1] = mem_q[rd1_idx].instr;
        deq_pc_o[1]    = mem_q[rd1_idx].pc;
        if (bypass) begin
            deq_v_o        = 2'b01;
            deq_instr_o[0] = enq_instr_i;
            deq_pc_o[0]    = enq_pc_i;
        end
    end

    deq_clamp_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) !clamp)
        else $warning("dual_issue_fetch_buffer: deq_count_i %0d clamped to %0d", deq_count_i, avail);

endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Directed bench for dual_issue_fetch_buffer (default build, no bypass).
module tb_dual_issue_fetch_buffer;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, enq_v;
    logic [31:0]      enq_instr, enq_pc;
    logic             enq_ready;
    logic [1:0]       deq_v;
    logic [1:0][31:0] deq_instr, deq_pc;
    logic [1:0]       deq_count;
    logic [3:0]       count;

    int checks = 0;
    int errors = 0;

    dual_issue_fetch_buffer #(.els_p(8), .instr_width_p(32), .pc_width_p(32)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush),
        .enq_v_i(enq_v), .enq_instr_i(enq_instr), .enq_pc_i(enq_pc),
        .enq_ready_o(enq_ready), .deq_v_o(deq_v), .deq_instr_o(deq_instr),
        .deq_pc_o(deq_pc), .deq_count_i(deq_count), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        enq_v = 1'b1; enq_instr = ins; enq_pc = pc;
        cyc();
        enq_v = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (deq_v !== 2'b00) begin errors++; $display("FAIL reset_deq_v got %b exp 00", deq_v); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", enq_ready); end
    endtask

    task automatic test_pair;
        push(32'h0000_0013, 32'h100);
        push(32'h0010_0093, 32'h104);
        checks++; if (deq_v !== 2'b11) begin errors++; $display("FAIL pair_deq_v got %b exp 11", deq_v); end
        checks++; if (deq_pc[0] !== 32'h100) begin errors++; $display("FAIL pair_pc0 got %h exp 100", deq_pc[0]); end
        checks++; if (deq_pc[1] !== 32'h104) begin errors++; $display("FAIL pair_pc1 got %h exp 104", deq_pc[1]); end
        checks++; if (deq_instr[1] !== 32'h0010_0093) begin errors++; $display("FAIL pair_instr1 got %h exp 00100093", deq_instr[1]); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL pair_count got %0d exp 2", count); end
        deq_count = 2'd2; cyc(); deq_count = 2'd0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL pair_drain got %0d exp 0", count); end
    endtask

    task automatic test_full;
        for (int k = 0; k < 8; k++) push(32'(k), 32'(k * 4));
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", enq_ready); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
        enq_v = 1'b1; enq_instr = 32'hDEAD; enq_pc = 32'hDEAD; deq_count = 2'd2;
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready_deq got %b exp 0", enq_ready); end
        cyc();
        enq_v = 1'b0; deq_count = 2'd0;
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_count_after got %0d exp 6", count); end
        checks++; if (deq_pc[0] !== 32'h8) begin errors++; $display("FAIL full_pc0 got %h exp 8", deq_pc[0]); end
        checks++; if (deq_pc[1] !== 32'hC) begin errors++; $display("FAIL full_pc1 got %h exp c", deq_pc[1]); end
        deq_count = 2'd2;
        repeat (3) cyc();
        deq_count = 2'd0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", count); end
    endtask

    // read index is 2 here; seven pushes fill indices 2..7,0 and five retires park rptr at 7
    task automatic test_wrap;
        for (int k = 0; k < 7; k++) push(32'h1000 + 32'(k), 32'h200 + 32'(k * 4));
        deq_count = 2'd2; cyc(); cyc();
        deq_count = 2'd1; cyc();
        deq_count = 2'd0;
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL wrap_count got %0d exp 2", count); end
        checks++; if (deq_v !== 2'b11) begin errors++; $display("FAIL wrap_deq_v got %b exp 11", deq_v); end
        checks++; if (deq_pc[0] !== 32'h214) begin errors++; $display("FAIL wrap_pc0 got %h exp 214", deq_pc[0]); end
        checks++; if (deq_pc[1] !== 32'h218) begin errors++; $display("FAIL wrap_pc1 got %h exp 218", deq_pc[1]); end
        deq_count = 2'd1; cyc(); deq_count = 2'd0;
        checks++; if (deq_pc[0] !== 32'h218) begin errors++; $display("FAIL wrap_pc0_next got %h exp 218", deq_pc[0]); end
        checks++; if (deq_v !== 2'b01) begin errors++; $display("FAIL wrap_deq_v_next got %b exp 01", deq_v); end
        deq_count = 2'd1; cyc(); deq_count = 2'd0;
    endtask

    task automatic test_flush;
        for (int k = 0; k < 5; k++) push(32'h2000 + 32'(k), 32'h600 + 32'(k * 4));
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        flush = 1'b1; enq_v = 1'b1; enq_instr = 32'h999; enq_pc = 32'h999;
        cyc();
        flush = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (deq_v !== 2'b00) begin errors++; $display("FAIL flush_deq_v got %b exp 00", deq_v); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", enq_ready); end
        cyc();
        enq_v = 1'b0;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b exp 1", enq_ready); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_absorb got %0d exp 0", count); end
    endtask

    task automatic test_clamp;
        push(32'h33, 32'h300);
        deq_count = 2'd2;
        checks++; if (deq_v !== 2'b01) begin errors++; $display("FAIL clamp_deq_v got %b exp 01", deq_v); end
        cyc();
        deq_count = 2'd0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL clamp_count got %0d exp 0", count); end
        push(32'h44, 32'h304);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL clamp_no_underflow got %0d exp 1", count); end
        checks++; if (deq_pc[0] !== 32'h304) begin errors++; $display("FAIL clamp_pc0 got %h exp 304", deq_pc[0]); end
        deq_count = 2'd1; cyc(); deq_count = 2'd0;
    endtask

    task automatic test_back_to_back;
        push(32'h400, 32'h400);
        push(32'h404, 32'h404);
        enq_v = 1'b1; enq_instr = 32'h408; enq_pc = 32'h408; deq_count = 2'd1;
        cyc();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
        checks++; if (deq_pc[0] !== 32'h404 || deq_pc[1] !== 32'h408) begin
            errors++; $display("FAIL b2b_pcs got %h/%h exp 404/408", deq_pc[0], deq_pc[1]); end
        enq_instr = 32'h40C; enq_pc = 32'h40C; deq_count = 2'd2;
        cyc();
        enq_v = 1'b0; deq_count = 2'd0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count2 got %0d exp 1", count); end
        checks++; if (deq_pc[0] !== 32'h40C) begin errors++; $display("FAIL b2b_pc0 got %h exp 40c", deq_pc[0]); end
        deq_count = 2'd1; cyc(); deq_count = 2'd0;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 4; k++) push(32'h3000 + 32'(k), 32'h700 + 32'(k * 4));
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL rmid_pre got %0d exp 4", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
        checks++; if (deq_v !== 2'b00) begin errors++; $display("FAIL rmid_deq_v got %b exp 00", deq_v); end
        #3 rst_n = 1'b1;
        cyc();
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", enq_ready); end
        push(32'h55, 32'h500);
        checks++; if (deq_v !== 2'b01 || deq_pc[0] !== 32'h500) begin
            errors++; $display("FAIL rmid_enq got v=%b pc=%h exp 01/500", deq_v, deq_pc[0]); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; enq_v = 1'b0;
        enq_instr = '0; enq_pc = '0; deq_count = 2'd0;
        #12;
        test_reset();
        rst_n = 1'b1;
        cyc();
        test_pair();
        test_full();
        test_wrap();
        test_flush();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completing sequence");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dual_issue_fetch_buffer.md
Name: dual_issue_fetch_buffer

Overview:
- Instruction queue sitting directly upstream of the dual-issue decoder.
- Buffers instructions returned by the icache in program order and presents the two oldest entries as an instruction pair (slot 0 = older).
- Retires 0, 1 or 2 entries per cycle as directed by the issue logic (single- vs dual-issue).
- Flushed on any PC redirect.

Parameters:
- els_p, 8, queue depth in instructions; power of 2, >= 4.
- instr_width_p, 32, instruction width.
- pc_width_p, 32, stored PC width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  PC redirect; discard all entries
- enq_v_i  in  1  icache response valid
- enq_instr_i  in  instr_width_p  instruction to enqueue
- enq_pc_i  in  pc_width_p  PC of enq_instr_i
- enq_ready_o  out  1  buffer can accept an entry this cycle
- deq_v_o  out  2  per-slot valid; bit0 = slot 0, bit1 = slot 1
- deq_instr_o  out  2 x instr_width_p  slot 0 / slot 1 instructions
- deq_pc_o  out  2 x pc_width_p  slot 0 / slot 1 PCs
- deq_count_i  in  2  entries consumed this cycle (0, 1 or 2); 3 is illegal
- count_o  out  $clog2(els_p)+1  current occupancy

Behaviour:
- Storage and pointers:
  - Circular buffer of {instr, pc}.
  - rptr/wptr carry an extra wrap bit; count_o = wptr - rptr.
  - full = (count_o == els_p); empty = (count_o == 0).
- Reset (reset_n_i low, asynchronous):
  - rptr = wptr = 0, state = RUN.
  - Outputs: count_o = 0, deq_v_o = 2'b00, enq_ready_o = 1.
  - Storage contents are not reset; slot data outputs are don't-care while invalid.
- State machine:
  - RUN:
    - enq_ready_o = !full.
    - flush_i -> FLUSH.
  - FLUSH (exactly one cycle, absorbs the in-flight icache response of the old path):
    - enq_ready_o = 0; enq_v_i is ignored.
    - Next state RUN, unless flush_i is asserted again, which keeps it in FLUSH.
- Flush:
  - In the cycle flush_i is high: rptr <= wptr (count -> 0 next cycle).
  - A concurrent enqueue is dropped.
  - deq_count_i is ignored.
- Enqueue:
  - Occurs when enq_v_i & enq_ready_o & !flush_i.
  - Writes at wptr; wptr++ wraps modulo 2*els_p.
- Dequeue outputs:
  - deq_v_o[0] = (count_o >= 1); deq_v_o[1] = (count_o >= 2).
  - Slot 0 = entry[rptr]; slot 1 = entry[rptr+1], wrapping index modulo els_p.
- Dequeue consumption:
  - rptr += deq_count_i.
  - deq_count_i greater than the number of valid slots, or equal to 3, is clamped to the valid count.
  - Simulation assertion fires on any such clamp.
- Simultaneous enqueue and dequeue:
  - Both happen in the same cycle; count_next = count + enq - deq.
  - enq_ready_o depends on current occupancy only, so a full buffer does not accept even if 2 entries retire that cycle.
- Latency (no bypass): an enqueued entry is visible on deq outputs the cycle after enqueue.
- Wrap-around: slot 1 must read physical index 0 when rptr index = els_p-1.
- Ordering: the buffer performs no dependency or type checks; it only guarantees program order.

Optional Feature:
- Macro: DUAL_ISSUE_FETCH_BUF_BYPASS_EN.
- Defined:
  - When the buffer is empty in RUN and an enqueue fires, enq_instr_i/enq_pc_i drive slot 0 combinationally and deq_v_o = 2'b01 in the same cycle.
  - If deq_count_i >= 1 in that cycle, the entry is consumed and not written (wptr and rptr both unchanged).
  - Otherwise it is written normally.
- Undefined: no bypass; 1-cycle minimum enqueue-to-visible latency.

Test Plan:
- Reset, then enqueue 0x00000013 @PC 0x100 and 0x00100093 @PC 0x104 on consecutive cycles, deq_count_i = 0 -> cycle after 2nd enqueue: deq_v_o = 2'b11, slot 0 PC 0x100, slot 1 PC 0x104, count_o = 2.
- Fill 8 entries (PC 0x0..0x1C) -> enq_ready_o = 0. Assert enq_v_i with deq_count_i = 2 -> no enqueue, count_o = 6, slot 0 PC 0x8.
- Wrap: advance rptr to index 7 with 2 entries valid -> slot 0 from index 7, slot 1 from index 0. deq_count_i = 1 -> slot 0 now from index 0.
- Flush with 5 entries valid and enq_v_i = 1 -> next cycle count_o = 0, deq_v_o = 0, enq_ready_o = 0. Following cycle enq_ready_o = 1.
- With 1 entry valid, drive deq_count_i = 2 -> count_o = 0, assertion reported, no pointer underflow.
- Assert reset_n_i low mid-stream with 4 entries valid -> count_o = 0, deq_v_o = 0 immediately (asynchronously), state RUN after release.
